// File: rtl/arith_result_queue.sv
// arith_result_queue: small FIFO between the arithmetic unit and writeback.
// Entries carry the result, its destination tag and zero/negative flags
// computed at capture. There is no bypass, so a pushed entry becomes visible
// one cycle later. A saturating counter tracks cycles where the arithmetic
// unit offered a result but the queue could not take it.
module arith_result_queue #(
    parameter int DEPTH = 2,
    parameter int TAGW  = 5,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              ArithAnswer,
    input  logic [TAGW-1:0]          in_dest,
    input  logic                     S_or_U,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              wb_data,
    output logic [TAGW-1:0]          wb_dest,
    output logic                     wb_zero,
    output logic                     wb_neg,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNTW-1:0]          stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Entry layout: {data[31:0], dest[TAGW-1:0], zero, neg}
    localparam int EW = 32 + TAGW + 2;

    logic [EW-1:0]   entryMem [DEPTH];
    logic [AW-1:0]   wrPtrReg, wrPtrNext;
    logic [AW-1:0]   rdPtrReg, rdPtrNext;
    logic [CW-1:0]   countReg, countNext;
    logic [CNTW-1:0] stallReg, stallNext;

    logic            push;
    logic            pop;
    logic            isFull;
    logic            entryZero;
    logic            entryNeg;
    logic [EW-1:0]   entryIn;
    logic [EW-1:0]   headEntry;

    // Full detection uses registered occupancy only, so a same-cycle pop never
    // opens a slot early and out_ready has no path to in_ready.
    assign isFull    = (countReg >= CW'(DEPTH));
    assign in_ready  = !isFull && !reset;
    assign out_valid = (countReg != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Flags are computed once at capture; unsigned results are never negative.
    assign entryZero = (ArithAnswer == 32'd0);
    assign entryNeg  = S_or_U && ArithAnswer[31];
    assign entryIn   = {ArithAnswer, in_dest, entryZero, entryNeg};

    // Storage write: no reset needed, stale slots are never visible because
    // out_valid masks the head when the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            entryMem[wrPtrReg] <= entryIn;
        end
    end

    // Head of queue drives writeback directly; zeros when nothing is valid.
    always_comb begin
        headEntry = entryMem[rdPtrReg];
        wb_data   = '0;
        wb_dest   = '0;
        wb_zero   = 1'b0;
        wb_neg    = 1'b0;
        if (out_valid) begin
            wb_data = headEntry[EW-1 -: 32];
            wb_dest = headEntry[TAGW+1 -: TAGW];
            wb_zero = headEntry[1];
            wb_neg  = headEntry[0];
        end
    end

    // Next-state for pointers, occupancy and the stall counter.
    always_comb begin
        wrPtrNext = wrPtrReg;
        rdPtrNext = rdPtrReg;
        countNext = countReg;
        stallNext = stallReg;

        if (push) begin
            wrPtrNext = (wrPtrReg == AW'(DEPTH - 1)) ? '0 : wrPtrReg + 1'b1;
        end
        if (pop) begin
            rdPtrNext = (rdPtrReg == AW'(DEPTH - 1)) ? '0 : rdPtrReg + 1'b1;
        end

        case ({push, pop})
            2'b10:   countNext = countReg + 1'b1;
            2'b01:   countNext = countReg - 1'b1;
            default: countNext = countReg;
        endcase

        // Saturate instead of wrapping so a long stall never reads as short.
        if (in_valid && !in_ready && (stallReg != {CNTW{1'b1}})) begin
            stallNext = stallReg + 1'b1;
        end
    end

    // State register with synchronous clear; reset drops all stored entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
            stallReg <= '0;
        end else begin
            wrPtrReg <= wrPtrNext;
            rdPtrReg <= rdPtrNext;
            countReg <= countNext;
            stallReg <= stallNext;
        end
    end

    assign count     = countReg;
    assign stall_cnt = stallReg;

endmodule
